snake_dir_ctrl: RTL

- Direction front-end for the snake game core.
- Conditions four raw push-buttons into the 2-bit `direction` code consumed by the game core: synchroniser, per-button debounce, press-edge detect, small turn queue.
- Rejects 180° reversals and commits at most one queued turn per game step, so quick double-taps between steps are not lost.
- Runs on the fast `game_clk` domain. The game core advances only when `step` is pulsed.

---
 rtl/snake_dir_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - push-button direction front-end for the snake game core
//
// Purpose: synchronises and debounces four raw buttons, turns debounced rising
// edges into turn requests, filters out no-op turns and 180-degree reversals,
// and holds accepted turns in a small FIFO that is drained one entry per step.
//
// Ports:
//   game_clk    in   1   clock, rising edge
//   reset_n     in   1   synchronous active-low reset
//   btn         in   4   raw buttons, index = direction code
//                        (0 DOWN, 1 UP, 2 LEFT, 3 RIGHT)
//   step        in   1   one-cycle strobe, commit the queue head
//   direction   out  2   committed direction
//   q_count     out  3   number of queued turns
//   turn_rej    out  1   one-cycle pulse for a rejected press
//   turn_count  out  16  (TURN_CNT_EN only) saturating count of direction changes
//
// Optional feature macro: TURN_CNT_EN

module snake_dir_ctrl #(
  parameter int DB_CYCLES   = 16,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        game_clk,
  input  logic        reset_n,
  input  logic [3:0]  btn,
  input  logic        step,
  output logic [1:0]  direction,
  output logic [2:0]  q_count,
  output logic        turn_rej
`ifdef TURN_CNT_EN
  ,
  output logic [15:0] turn_count
`endif
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(QUEUE_DEPTH - 1);
  localparam logic [2:0]    Q_FULL  = 3'(QUEUE_DEPTH);

  logic [3:0]    sync1, sync2, db_level, db_prev;
  logic [CW-1:0] db_cnt [4];

  logic [1:0]    q_mem [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, last_idx;

  logic [3:0]    press_vec;
  logic          press_valid;
  logic [1:0]    press_code;
  logic [1:0]    ref_dir;
  logic          q_full, do_push, do_pop, do_rej;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  // Synchroniser and per-bit debounce. The counter only runs while the
  // synchronised sample disagrees with the accepted level, so it is
  // cleared on the flip and can never wrap.
  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db_level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db_level[i]) begin
          if (db_cnt[i] == CNT_MAX) begin
            db_level[i] <= sync2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press_vec = db_level & ~db_prev;

  // Lowest index wins when several buttons settle together; the
  // scan runs downwards so the last hit is the lowest code.
  always_comb begin
    press_valid = 1'b0;
    press_code  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press_vec[i]) begin
        press_valid = 1'b1;
        press_code  = 2'(i);
      end
    end
  end

  // Turns are judged against where the snake will be heading once the
  // queue drains, i.e. the newest queued entry, not the current direction.
  assign last_idx = (wr_ptr == '0) ? PTR_MAX : wr_ptr - PW'(1);
  assign ref_dir  = (q_count != 3'd0) ? q_mem[last_idx] : direction;
  assign q_full   = (q_count == Q_FULL);
  assign do_pop   = step && (q_count != 3'd0);

  // A full queue still accepts a push when a pop frees the head slot
  // in the same cycle.
  always_comb begin
    do_push = 1'b0;
    do_rej  = 1'b0;
    if (press_valid && (press_code != ref_dir)) begin
      if (press_code == (ref_dir ^ 2'b01))
        do_rej = 1'b1;
      else if (q_full && !step)
        do_rej = 1'b1;
      else
        do_push = 1'b1;
    end
  end

  always_ff @(posedge game_clk) begin
    if (do_push) q_mem[wr_ptr] <= press_code;
  end

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_count   <= 3'd0;
      direction <= 2'd3;
      turn_rej  <= 1'b0;
    end else begin
      turn_rej <= do_rej;
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        direction <= q_mem[rd_ptr];
        rd_ptr    <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   q_count <= q_count + 3'd1;
        2'b01:   q_count <= q_count - 3'd1;
        default: q_count <= q_count;
      endcase
    end
  end

`ifdef TURN_CNT_EN
  always_ff @(posedge game_clk) begin
    if (!reset_n)
      turn_count <= 16'd0;
    else if (do_pop && (q_mem[rd_ptr] != direction) && (turn_count != 16'hFFFF))
      turn_count <= turn_count + 16'd1;
  end
`endif

endmodule
